// File: rtl/aer_pkg.sv
// Shared AER definitions: default widths and the event record used by the
// arbiter, packetizer and depacketizer.
package aer_pkg;

    localparam int N_CH   = 16;
    localparam int CH_W   = 4;
    localparam int TS_W   = 16;
    localparam int DROP_W = 16;

    typedef struct packed {
        logic [CH_W-1:0] addr;
        logic [TS_W-1:0] ts;
    } aer_event_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request searching upward from
// ptr+1, wrapping modulo N. N must be a power of two equal to 2**W.
module rr_pick #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any
);

    logic [W-1:0]   start;
    logic [W-1:0]   off;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    // NOTE: every output of this always_comb is assigned on every path before use, so no latch is inferred.
    always_comb begin
        start = ptr + 1'b1;
        // Rotate so the first candidate lands at bit 0, then find the lowest set bit.
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = W'(i);
        end
        // W-bit addition wraps modulo N, undoing the rotation.
        winner = start + off;
        any    = |req;
    end

endmodule

// File: rtl/aer_spike_arbiter.sv
// Merges per-channel spike pulses into a single timestamped address-event
// stream with round-robin fairness and saturating drop accounting.
module aer_spike_arbiter #(
    parameter int N_CH   = aer_pkg::N_CH,
    parameter int CH_W   = aer_pkg::CH_W,
    parameter int TS_W   = aer_pkg::TS_W,
    parameter int DROP_W = aer_pkg::DROP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              tick,
    input  logic [N_CH-1:0]   spike_in,
    output logic              aer_valid,
    input  logic              aer_ready,
    output logic [CH_W-1:0]   aer_addr,
    output logic [TS_W-1:0]   aer_ts,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              drop_flag,
    input  logic              clr_drop
);

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] grant_vec;
    logic [N_CH-1:0] drops;
    logic [TS_W-1:0] ts_cnt;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] winner;
    logic            any_req;
    logic            slot_free;
    logic            grant;
    logic [DROP_W:0] drop_sum;

    rr_pick #(
        .N (N_CH),
        .W (CH_W)
    ) u_pick (
        .req    (pending),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    always_comb begin
        slot_free = !aer_valid || aer_ready;
        grant     = slot_free && enable && any_req;
        grant_vec = '0;
        if (grant) grant_vec[winner] = 1'b1;
        // A spike is lost only if its channel is already pending and not being served now.
        drops    = spike_in & pending & ~grant_vec;
        drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'($countones(drops));
    end

    // NOTE: state uses non-blocking assignments with an asynchronous active-low reset so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            ts_cnt    <= '0;
            rr_ptr    <= CH_W'(N_CH - 1);
            aer_valid <= 1'b0;
            aer_addr  <= '0;
            aer_ts    <= '0;
            drop_cnt  <= '0;
            drop_flag <= 1'b0;
        end else begin
            // OR-ing after the clear keeps a new spike that coincides with its own grant.
            pending <= (pending & ~grant_vec) | spike_in;

            if (tick) ts_cnt <= ts_cnt + 1'b1;

            if (grant) begin
                aer_valid <= 1'b1;
                aer_addr  <= winner;
                aer_ts    <= ts_cnt;
                rr_ptr    <= winner;
            end else if (slot_free) begin
                aer_valid <= 1'b0;
            end

            if (clr_drop) begin
                drop_cnt  <= DROP_W'($countones(drops));
                drop_flag <= |drops;
            end else begin
                drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
                if (|drops) drop_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aer_spike_arbiter.sv
// Directed self-checking bench for aer_spike_arbiter with an event scoreboard.
module tb_aer_spike_arbiter;
    import aer_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              tick;
    logic [N_CH-1:0]   spike_in;
    logic              aer_valid;
    logic              aer_ready;
    logic [CH_W-1:0]   aer_addr;
    logic [TS_W-1:0]   aer_ts;
    logic [DROP_W-1:0] drop_cnt;
    logic              drop_flag;
    logic              clr_drop;

    aer_event_t     sb[$];
    logic [TS_W-1:0] tb_ts;
    int checks   = 0;
    int failures = 0;

    aer_spike_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .tick      (tick),
        .spike_in  (spike_in),
        .aer_valid (aer_valid),
        .aer_ready (aer_ready),
        .aer_addr  (aer_addr),
        .aer_ts    (aer_ts),
        .drop_cnt  (drop_cnt),
        .drop_flag (drop_flag),
        .clr_drop  (clr_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int addr, input logic [TS_W-1:0] ts);
        aer_event_t ev;
        ev.addr = CH_W'(addr);
        ev.ts   = ts;
        sb.push_back(ev);
    endtask

    // Scores any handshake happening at the coming edge, then advances one cycle.
    task automatic cycle();
        aer_event_t ev;
        if (rst_n && aer_valid && aer_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                ev = sb.pop_front();
                check("ev_addr", 32'(aer_addr), 32'(ev.addr));
                check("ev_ts", 32'(aer_ts), 32'(ev.ts));
            end
        end
        if (rst_n && tick) tb_ts++;
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        tb_ts = '0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        tick      = 1'b0;
        spike_in  = '0;
        aer_ready = 1'b1;
        clr_drop  = 1'b0;
        tb_ts     = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_valid", 32'(aer_valid), 32'd0);
        check("rst_addr", 32'(aer_addr), 32'd0);
        check("rst_ts", 32'(aer_ts), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_drop_flag", 32'(drop_flag), 32'd0);
        rst_n = 1'b1;

        // Single spike: pending one cycle later, event two cycles later
        cycles(4);
        spike_in = 16'h0001;
        push(0, tb_ts);
        cycle();
        spike_in = '0;
        check("lat_t1_valid", 32'(aer_valid), 32'd0);
        cycle();
        check("lat_t2_valid", 32'(aer_valid), 32'd1);
        check("lat_t2_addr", 32'(aer_addr), 32'd0);
        cycle();
        check("lat_t3_valid", 32'(aer_valid), 32'd0);
        drain(4);

        // Four simultaneous spikes drain one per cycle in ascending order
        do_reset();
        spike_in = 16'h8421;
        push(0, tb_ts); push(5, tb_ts); push(10, tb_ts); push(15, tb_ts);
        cycle();
        spike_in = '0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            check("burst_valid", 32'(aer_valid), 32'd1);
            cycle();
        end
        check("burst_end_valid", 32'(aer_valid), 32'd0);
        drain(4);
        spike_in = 16'h0003;
        push(0, tb_ts); push(1, tb_ts);
        cycle();
        spike_in = '0;
        drain(6);
        spike_in = 16'h0003;
        push(0, tb_ts); push(1, tb_ts);
        cycle();
        spike_in = '0;
        drain(6);

        // Backpressure hold, re-pend and drop on channel 3
        aer_ready = 1'b0;
        spike_in  = 16'h0008;
        push(3, tb_ts);
        cycle();
        spike_in = '0;
        cycle();
        check("bp_valid", 32'(aer_valid), 32'd1);
        tick = 1'b1;
        cycles(10);
        tick = 1'b0;
        check("bp_addr_hold", 32'(aer_addr), 32'd3);
        check("bp_ts_hold", 32'(aer_ts), 32'd0);
        check("bp_valid_hold", 32'(aer_valid), 32'd1);
        spike_in = 16'h0008;
        push(3, tb_ts);
        cycle();
        check("bp_no_drop", 32'(drop_cnt), 32'd0);
        cycle();
        spike_in = '0;
        check("bp_drop_cnt", 32'(drop_cnt), 32'd1);
        check("bp_drop_flag", 32'(drop_flag), 32'd1);
        aer_ready = 1'b1;
        drain(6);
        clr_drop = 1'b1;
        cycle();
        clr_drop = 1'b0;
        check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        check("clr_drop_flag", 32'(drop_flag), 32'd0);

        // Timestamp taken at grant after 100 ticks
        do_reset();
        tick = 1'b1;
        cycles(100);
        tick = 1'b0;
        spike_in = 16'h0004;
        push(2, tb_ts);
        cycle();
        spike_in = '0;
        drain(4);
        check("ts_model_100", 32'(tb_ts), 32'd100);

        // Drop saturation with grants held off; timestamp keeps ticking
        enable   = 1'b0;
        tick     = 1'b1;
        spike_in = 16'hFFFF;
        cycle();
        cycles(4095);
        spike_in = 16'h3FFF;
        cycle();
        check("sat_fffe", 32'(drop_cnt), 32'hFFFE);
        spike_in = 16'h0003;
        cycle();
        check("sat_ffff", 32'(drop_cnt), 32'hFFFF);
        spike_in = 16'h0001;
        cycle();
        check("sat_stays", 32'(drop_cnt), 32'hFFFF);
        clr_drop = 1'b1;
        cycle();
        clr_drop = 1'b0;
        spike_in = '0;
        check("clr_with_drop", 32'(drop_cnt), 32'd1);
        check("clr_with_drop_flag", 32'(drop_flag), 32'd1);

        // Run the timestamp to all-ones, one more tick wraps it to zero
        while (tb_ts != '1) cycle();
        cycle();
        tick = 1'b0;
        check("ts_model_wrap", 32'(tb_ts), 32'd0);
        for (int i = 3; i < 19; i++) push(i % 16, tb_ts);
        enable = 1'b1;
        drain(40);

        // Enable gating, then reset mid-drain
        do_reset();
        enable   = 1'b0;
        spike_in = 16'h0012;
        cycle();
        spike_in = '0;
        cycles(3);
        check("en0_valid", 32'(aer_valid), 32'd0);
        push(1, tb_ts); push(4, tb_ts);
        enable = 1'b1;
        cycle();
        check("en1_addr1", 32'(aer_addr), 32'd1);
        cycle();
        check("en1_addr4", 32'(aer_addr), 32'd4);
        check("en1_valid", 32'(aer_valid), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_valid", 32'(aer_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("post_rst_idle", 32'(aer_valid), 32'd0);
        end
        check("post_rst_drop", 32'(drop_cnt), 32'd0);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
